// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic-light block and its pedestrian front end.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    ISSUE,
    LOCKOUT
  } ped_state_t;

  localparam int unsigned PED_DEBOUNCE_DEF = 4;
  // One full light cycle, so a request can be served at most once per cycle.
  localparam int unsigned PED_LOCKOUT_DEF  = 75;

  // Width of an unsigned counter that must be able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-flop synchroniser, stability-count debounce and a rising-edge press pulse.
module btn_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = PED_DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            btn_s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            db_prev_q;
  logic            press_q;

  assign btn_s = sync_q[1];

  // The counter only advances while the synchronised level disagrees with btn_db.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (btn_s != db_q) begin
      if (cnt_q == CntLast) begin
        db_d = btn_s;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw_i};
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
    end
  end

  assign press_o = press_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CntLast);
  a_press_single: assert property (@(posedge clk) disable iff (!rst_n) press_q |=> !press_q);

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request conditioner: queues a debounced press and hands it to the light controller
// as a one-cycle pulse during green, then locks out further presses for a light cycle.
module ped_request_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = PED_DEBOUNCE_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = PED_LOCKOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic green,
  output logic pass_request,
  output logic req_pending
);

  localparam int unsigned LockW = cnt_width(LOCKOUT_CYCLES);
  localparam logic [LockW-1:0] LockLast = LockW'(LOCKOUT_CYCLES - 1);

  logic             press;
  ped_state_t       state_q;
  logic [LockW-1:0] lock_cnt_q;
  logic             pass_request_q;
  logic             req_pending_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw_i(btn_raw),
    .press_o  (press)
  );

  // Outputs are set on entry to their state so they are pure flops, never decoded from inputs.
  // Presses outside IDLE fall through untouched: absorbed while queued, dropped in lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lock_cnt_q     <= '0;
      pass_request_q <= 1'b0;
      req_pending_q  <= 1'b0;
    end else begin
      pass_request_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press) begin
            state_q       <= PENDING;
            req_pending_q <= 1'b1;
          end
        end
        PENDING: begin
          if (green) begin
            state_q        <= ISSUE;
            req_pending_q  <= 1'b0;
            pass_request_q <= 1'b1;
          end
        end
        ISSUE: begin
          state_q    <= LOCKOUT;
          lock_cnt_q <= '0;
        end
        LOCKOUT: begin
          if (lock_cnt_q == LockLast) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + LockW'(1);
          end
        end
        default: begin
          state_q        <= IDLE;
          lock_cnt_q     <= '0;
          req_pending_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pass_request = pass_request_q;
  assign req_pending  = req_pending_q;

  a_pulse_single: assert property (@(posedge clk) disable iff (!rst_n)
    pass_request |=> !pass_request);
  a_pulse_state: assert property (@(posedge clk) disable iff (!rst_n)
    pass_request == (state_q == ISSUE));
  a_pending_state: assert property (@(posedge clk) disable iff (!rst_n)
    req_pending == (state_q == PENDING));
  a_lock_bound: assert property (@(posedge clk) disable iff (!rst_n) lock_cnt_q <= LockLast);

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Scenario bench for ped_request_ctrl: per-cycle expectations are queued as stimulus is applied
// and popped when the next clock edge has produced the DUT outputs.
module tb_ped_request_ctrl;
  import traffic_pkg::*;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic btn_raw = 1'b0;
  logic green   = 1'b0;
  logic pass_request;
  logic req_pending;

  typedef struct {
    logic pr;
    logic rp;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   pulse_cyc   = 0;

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (75)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .green       (green),
    .pass_request(pass_request),
    .req_pending (req_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic pr, input logic rp);
    exp_t x;
    x.pr = pr;
    x.rp = rp;
    sb_q.push_back(x);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    green   = 1'b0;
    repeat (3) tick();
    push(1'b0, 1'b0);
    e = sb_q.pop_front();
    vectors++;
    if (pass_request !== e.pr) begin
      miscompares++;
      $display("FAIL reset.pass_request cyc=%0d got=%b exp=%b", cyc, pass_request, e.pr);
    end
    vectors++;
    if (req_pending !== e.rp) begin
      miscompares++;
      $display("FAIL reset.req_pending cyc=%0d got=%b exp=%b", cyc, req_pending, e.rp);
    end
    vectors++;
    if (dut.state_q !== IDLE) begin
      miscompares++;
      $display("FAIL reset.state cyc=%0d got=%0d exp=%0d", cyc, dut.state_q, IDLE);
    end
    vectors++;
    if (dut.u_debounce.db_q !== 1'b0) begin
      miscompares++;
      $display("FAIL reset.btn_db cyc=%0d got=%b exp=0", cyc, dut.u_debounce.db_q);
    end
    rst_n = 1'b1;
    repeat (3) begin
      push(1'b0, 1'b0);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (pass_request !== e.pr || req_pending !== e.rp) begin
        miscompares++;
        $display("FAIL reset.idle cyc=%0d got=%b%b exp=%b%b", cyc, pass_request, req_pending,
                 e.pr, e.rp);
      end
    end
  endtask

  task automatic test_bounce();
    green = 1'b0;
    for (int i = 0; i < 24; i++) begin
      btn_raw = (i < 12) && ((i % 4) < 2);
      push(1'b0, 1'b0);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (pass_request !== e.pr || req_pending !== e.rp) begin
        miscompares++;
        $display("FAIL bounce.outputs cyc=%0d got=%b%b exp=%b%b", cyc, pass_request, req_pending,
                 e.pr, e.rp);
      end
      vectors++;
      if (dut.u_debounce.db_q !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce.btn_db cyc=%0d got=%b exp=0", cyc, dut.u_debounce.db_q);
      end
    end
  endtask

  task automatic test_clean_press();
    green   = 1'b0;
    btn_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      push(1'b0, i >= 8);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (pass_request !== e.pr) begin
        miscompares++;
        $display("FAIL clean_press.pass_request i=%0d got=%b exp=%b", i, pass_request, e.pr);
      end
      vectors++;
      if (req_pending !== e.rp) begin
        miscompares++;
        $display("FAIL clean_press.req_pending i=%0d got=%b exp=%b", i, req_pending, e.rp);
      end
    end
    btn_raw = 1'b0;
  endtask

  task automatic test_deferred_issue();
    for (int i = 0; i < 5; i++) begin
      green = (i >= 3);
      push(i == 3, i < 3);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (pass_request !== e.pr || req_pending !== e.rp) begin
        miscompares++;
        $display("FAIL deferred.outputs i=%0d got=%b%b exp=%b%b", i, pass_request, req_pending,
                 e.pr, e.rp);
      end
      if (i == 3) pulse_cyc = cyc;
    end
    vectors++;
    if (dut.state_q !== LOCKOUT) begin
      miscompares++;
      $display("FAIL deferred.state cyc=%0d got=%0d exp=%0d", cyc, dut.state_q, LOCKOUT);
    end
  endtask

  // Press early in lockout, press landing exactly on the lockout exit edge, then a legal press.
  task automatic test_lockout();
    int d;
    green = 1'b1;
    while (cyc < pulse_cyc + 100) begin
      d = cyc - pulse_cyc;
      btn_raw = (d >= 9 && d < 15) || (d >= 68 && d < 80) || (d >= 90);
      push((d + 1) == 99, (d + 1) == 98);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (pass_request !== e.pr) begin
        miscompares++;
        $display("FAIL lockout.pass_request d=%0d got=%b exp=%b", d + 1, pass_request, e.pr);
      end
      vectors++;
      if (req_pending !== e.rp) begin
        miscompares++;
        $display("FAIL lockout.req_pending d=%0d got=%b exp=%b", d + 1, req_pending, e.rp);
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    btn_raw = 1'b0;
    green   = 1'b0;
    rst_n   = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    btn_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 9) btn_raw = 1'b0;
      push(1'b0, i >= 8);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (pass_request !== e.pr || req_pending !== e.rp) begin
        miscompares++;
        $display("FAIL mid_reset.press i=%0d got=%b%b exp=%b%b", i, pass_request, req_pending,
                 e.pr, e.rp);
      end
    end
    btn_raw = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    push(1'b0, 1'b0);
    e = sb_q.pop_front();
    vectors++;
    if (pass_request !== e.pr || req_pending !== e.rp) begin
      miscompares++;
      $display("FAIL mid_reset.async got=%b%b exp=%b%b", pass_request, req_pending, e.pr, e.rp);
    end
    tick();
    rst_n = 1'b1;
    green = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(1'b0, 1'b0);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (pass_request !== e.pr || req_pending !== e.rp) begin
        miscompares++;
        $display("FAIL mid_reset.no_pulse i=%0d got=%b%b exp=%b%b", i, pass_request, req_pending,
                 e.pr, e.rp);
      end
    end
  endtask

  task automatic test_held_through_reset();
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    green   = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      push(i == 9, i == 8);
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (pass_request !== e.pr) begin
        miscompares++;
        $display("FAIL held.pass_request i=%0d got=%b exp=%b", i, pass_request, e.pr);
      end
      vectors++;
      if (req_pending !== e.rp) begin
        miscompares++;
        $display("FAIL held.req_pending i=%0d got=%b exp=%b", i, req_pending, e.rp);
      end
    end
    btn_raw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_deferred_issue();
    test_lockout();
    test_reset_mid_pending();
    test_held_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
